// File: rtl/mul32_seq_if.sv
// Handshake/operand bundle between a controller (master) and mul32_seq (slave).
// The controller drives start/a/b and watches busy/done/product.
interface mul32_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mul32_seq.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier built around one add32.
// Optional macro MUL32_ZERO_BYPASS_EN: zero operands skip RUN and finish in one cycle.

module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [32:0] carry;

  always_comb begin
    carry[0] = cin;
    for (int i = 0; i < 32; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[32];
  end
endmodule

module mul32_seq (
  input  logic        clk,
  input  logic        reset,
  mul32_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] mcand;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [5:0]  count;
  logic [63:0] product_r;
  logic [31:0] addend;
  logic [31:0] sum;
  logic        cout;
  logic        accept;
  logic        zero_op;
  logic        last;
  logic [63:0] shifted;

  assign addend  = acc_lo[0] ? mcand : 32'd0;
  assign accept  = (state == IDLE) && bus.start;
  assign last    = (count == 6'd31);
  assign shifted = {cout, sum, acc_lo[31:1]};

`ifdef MUL32_ZERO_BYPASS_EN
  assign zero_op = (bus.a == 32'd0) || (bus.b == 32'd0);
`else
  assign zero_op = 1'b0;
`endif

  add32 u_add32 (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (bus.start) next_state = zero_op ? DONE : RUN;
      RUN:  if (last)      next_state = DONE;
      DONE:                next_state = IDLE;
      default:             next_state = IDLE;
    endcase
  end

  // The carry-out becomes bit 63 of the shifted accumulator every iteration,
  // and the final shifted value is latched straight into product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      count     <= '0;
      product_r <= '0;
    end else if (accept) begin
      mcand     <= bus.a;
      acc_hi    <= '0;
      acc_lo    <= bus.b;
      count     <= '0;
      product_r <= '0;
    end else if (state == RUN) begin
      {acc_hi, acc_lo} <= shifted;
      count            <= count + 6'd1;
      if (last) product_r <= shifted;
    end
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  assign bus.product = product_r;
endmodule

// File: tb/tb_mul32_seq.sv
// Directed self-checking bench for mul32_seq: latency, arithmetic corners,
// ignored start while busy, asynchronous reset and back-to-back operation.
module tb_mul32_seq;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mul32_seq_if bus ();

  mul32_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef MUL32_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] av, input logic [31:0] bv);
    bus.start = s;
    bus.a     = av;
    bus.b     = bv;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Position 1 is the cycle right after the accepting edge; bounded wait.
  task automatic waitDone(input int startLat, output int lat);
    lat = startLat;
    while (bus.done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic runOp(input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] expProd, input int expLat, input string tag);
    int lat;
    applyStimulus(1'b1, av, bv);
    tick();
    applyStimulus(1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd1);
    waitDone(1, lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, "_product"}, bus.product, expProd);
    tick();
    checkOutput({tag, "_done_drop"}, 64'(bus.done), 64'd0);
    checkOutput({tag, "_idle"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, "_hold"}, bus.product, expProd);
  endtask

  initial begin
    int lat;
    int seen;

    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0);
    tick(2);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_product", bus.product, 64'd0);
    reset = 1'b0;
    tick();

    runOp(32'd3, 32'd5, 64'h0000_0000_0000_000F, 33, "mul_3x5");
    runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, "mul_max");
    runOp(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 33, "mul_msb");
    runOp(32'd0, 32'd7, 64'd0, ZERO_LAT, "mul_zero");

    // Start pulsed mid-RUN must be ignored.
    applyStimulus(1'b1, 32'd10, 32'd10);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0);
    tick(4);
    applyStimulus(1'b1, 32'd2, 32'd2);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0);
    waitDone(6, lat);
    checkOutput("ign_latency", 64'(lat), 64'd33);
    checkOutput("ign_product", bus.product, 64'd100);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) seen++;
    end
    checkOutput("ign_no_second_done", 64'(seen), 64'd0);
    checkOutput("ign_hold", bus.product, 64'd100);

    // Asynchronous reset mid-RUN, asserted away from a clock edge.
    applyStimulus(1'b1, 32'd123, 32'd456);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0);
    tick(11);
    checkOutput("rst_mid_busy_before", 64'(bus.busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_mid_done", 64'(bus.done), 64'd0);
    checkOutput("rst_mid_product", bus.product, 64'd0);
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) seen++;
    end
    checkOutput("rst_mid_no_done", 64'(seen), 64'd0);
    runOp(32'd6, 32'd7, 64'd42, 33, "mul_after_rst");

    // Back-to-back with start held high.
    applyStimulus(1'b1, 32'd1000, 32'd1000);
    tick();
    applyStimulus(1'b1, 32'd65536, 32'd65536);
    waitDone(1, lat);
    checkOutput("b2b_first_latency", 64'(lat), 64'd33);
    checkOutput("b2b_first_product", bus.product, 64'd1000000);
    tick();
    waitDone(1, lat);
    checkOutput("b2b_spacing", 64'(lat), 64'd34);
    checkOutput("b2b_second_product", bus.product, 64'h0000_0001_0000_0000);
    applyStimulus(1'b0, 32'd0, 32'd0);
    tick(2);
    checkOutput("b2b_idle", 64'(bus.busy), 64'd0);
    checkOutput("b2b_hold", bus.product, 64'h0000_0001_0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul32_seq.md
Name: mul32_seq

Overview:
- Sequential unsigned 32x32->64 shift-and-add multiplier.
- Sits directly upstream of the team's 32-bit ripple-carry adder: instantiates exactly one add32 and feeds it a partial-product addend every cycle.
- One add per cycle, 32 iterations per product; `start`/`busy`/`done` handshake toward the controller.

Parameters:
- None. Width is fixed at 32 to match add32.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  32  multiplicand, captured on accepted start
- b  input  32  multiplier, captured on accepted start
- busy  output  1  high in RUN and DONE; start ignored while high
- done  output  1  one-cycle pulse, product valid
- product  output  64  result; held until the next accepted start

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy=0, done=0, product=0; internal acc_hi, acc_lo, mcand and count cleared. Applies immediately, including mid-operation; the in-flight result is discarded.
- Registers:
  - mcand[31:0]
  - acc_hi[31:0]
  - acc_lo[31:0], which initially holds the multiplier
  - count[5:0]
- States: IDLE, RUN, DONE.
- IDLE, start=1 at a rising edge:
  - mcand<=a, acc_hi<=0, acc_lo<=b, count<=0.
  - product<=0, which is cleared on every new start.
  - -> RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - add32 inputs: a=acc_hi, b=(acc_lo[0] ? mcand : 0), cin=0.
  - Next-state update: {acc_hi, acc_lo} <= {cout, sum, acc_lo[31:1]}, a 65-bit right shift by 1 where cout becomes bit 63.
  - count<=count+1.
  - When count==31 at the edge, -> DONE.
- RUN lasts exactly 32 cycles.
- DONE (one cycle): product={acc_hi,acc_lo}, done=1, busy=1. Next edge -> IDLE.
- Latency: start accepted at edge E0; done high in the cycle following edge E32, i.e. 33 cycles after acceptance.
- After DONE, product stays stable until the next accepted start.
- start held high continuously: a new operation is accepted in the first IDLE cycle after DONE, giving a throughput of one product per 34 cycles.
- start while busy: ignored, no queueing. Operands presented then are not captured.
- a and b may change freely after acceptance; they are not sampled during RUN.
- Arithmetic: unsigned only. No overflow is possible, since 64 bits holds the full product.
- The add32 carry-out is never discarded; it is the new MSB each iteration.
- done is a registered output, asserted only in the DONE state.

Optional Feature:
- Macro: MUL32_ZERO_BYPASS_EN.
- When defined:
  - On an accepted start with a==0 or b==0, the FSM goes IDLE->DONE directly, skipping RUN.
  - product=0, done pulses in the cycle after acceptance (latency 1).
- When undefined: every operation takes the full 32-cycle RUN, including zero operands (latency 33).
- Nonzero operands behave identically either way.

Test Plan:
- Reset, then a=3, b=5, 1-cycle start -> busy=1 from next cycle; done pulses 33 cycles after acceptance with product=64'h0000_0000_0000_000F; busy=0 afterwards and product holds.
- a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001. Checks the cout shift into bit 63.
- a=32'h8000_0000, b=2 -> product=64'h0000_0001_0000_0000. Then immediately a=0, b=7: product=0, with done at latency 1 if MUL32_ZERO_BYPASS_EN is defined, otherwise latency 33.
- Start a=10, b=10; at cycle 5 of RUN pulse start with a=2, b=2 -> ignored; the single done reports product=100; no second done follows.
- Start a=123, b=456; assert reset at RUN cycle 12 for 1 cycle -> busy, done and product go to 0 immediately and asynchronously; no done pulse. A new start a=6, b=7 then yields 42 with normal latency.
- Back-to-back: start held high with a=1000, b=1000 then a=65536, b=65536 -> products 1000000 and 64'h0000_0001_0000_0000, with done pulses 34 cycles apart.
